// File: rtl/pipe_pkg.sv
// Shared constants for the fetch/execute/parity pipeline and its issue queue.
package pipe_pkg;

  localparam int CODE_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  localparam logic [15:0] OP_NOP = 16'h0000;
  localparam logic [15:0] OP_ADD = 16'h0004;

endpackage

// File: rtl/pipe_retire_tracker.sv
// Fixed-latency {valid,tag} delay line mirroring the downstream pipeline depth.
module pipe_retire_tracker #(
  parameter int PIPE_LAT = 3,
  parameter int TAG_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  output logic             ret_valid,
  output logic [TAG_W-1:0] ret_tag
);

  // Element 0 is the live input; elements 1..PIPE_LAT are registered stages.
  logic             vld_chain [PIPE_LAT+1];
  logic [TAG_W-1:0] tag_chain [PIPE_LAT+1];

  assign vld_chain[0] = in_valid;
  assign tag_chain[0] = in_tag;

  genvar gi;
  generate
    for (gi = 0; gi < PIPE_LAT; gi++) begin : g_stage
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld_chain[gi+1] <= 1'b0;
          tag_chain[gi+1] <= '0;
        end else begin
          vld_chain[gi+1] <= vld_chain[gi];
          tag_chain[gi+1] <= tag_chain[gi];
        end
      end
    end
  endgenerate

  assign ret_valid = vld_chain[PIPE_LAT];
  assign ret_tag   = tag_chain[PIPE_LAT];

endmodule

// File: rtl/pipe_issue_queue.sv
// Operand-tuple queue feeding the pipeline fetch stage, one issue per cycle,
// with a tagged retire strobe PIPE_LAT cycles after each issue.
module pipe_issue_queue
  import pipe_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int CODE_W   = CODE_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int PIPE_LAT = 3,
  parameter int TAG_W    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CODE_W-1:0]        in_code,
  input  logic [DATA_W-1:0]        in_a,
  input  logic [DATA_W-1:0]        in_b,
  input  logic                     hold,
  output logic                     out_valid,
  output logic [CODE_W-1:0]        out_code,
  output logic [DATA_W-1:0]        out_a,
  output logic [DATA_W-1:0]        out_b,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     ret_valid,
  output logic [TAG_W-1:0]         ret_tag,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = CODE_W + 2 * DATA_W;

  logic [ENT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  head_reg, tail_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [TAG_W-1:0]  tag_reg;
  logic              out_valid_reg;
  logic [CODE_W-1:0] out_code_reg;
  logic [DATA_W-1:0] out_a_reg, out_b_reg;
  logic [TAG_W-1:0]  out_tag_reg;
  logic              push, issue;

  // Readiness looks only at the pre-edge count: no push-through when full.
  assign in_ready = rst & (count_reg < CNT_W'(DEPTH));
  assign push     = in_valid & in_ready;
  assign issue    = (count_reg != '0) & ~hold;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail_reg] <= {in_code, in_a, in_b};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      tag_reg   <= '0;
    end else begin
      if (push) begin
        tail_reg <= tail_reg + 1'b1;
      end
      if (issue) begin
        head_reg <= head_reg + 1'b1;
        tag_reg  <= tag_reg + 1'b1;
      end
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(issue);
    end
  end

  // Issue register presents NOP/zero whenever nothing issues this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_reg <= 1'b0;
      out_code_reg  <= CODE_W'(OP_NOP);
      out_a_reg     <= '0;
      out_b_reg     <= '0;
      out_tag_reg   <= '0;
    end else if (issue) begin
      out_valid_reg <= 1'b1;
      {out_code_reg, out_a_reg, out_b_reg} <= mem[head_reg];
      out_tag_reg   <= tag_reg;
    end else begin
      out_valid_reg <= 1'b0;
      out_code_reg  <= CODE_W'(OP_NOP);
      out_a_reg     <= '0;
      out_b_reg     <= '0;
    end
  end

  pipe_retire_tracker #(
    .PIPE_LAT (PIPE_LAT),
    .TAG_W    (TAG_W)
  ) u_retire (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (out_valid_reg),
    .in_tag    (out_tag_reg),
    .ret_valid (ret_valid),
    .ret_tag   (ret_tag)
  );

  assign out_valid = out_valid_reg;
  assign out_code  = out_code_reg;
  assign out_a     = out_a_reg;
  assign out_b     = out_b_reg;
  assign out_tag   = out_tag_reg;
  assign count     = count_reg;

endmodule

// File: tb/tb_pipe_issue_queue.sv
// Scoreboard bench for pipe_issue_queue: a reference model queues expected
// issues and retires; a negedge monitor pops and compares them.
module tb_pipe_issue_queue;
  import pipe_pkg::*;

  localparam int DEPTH = 4;
  localparam int LAT   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, hold;
  logic [15:0] in_code, out_code;
  logic [31:0] in_a, in_b, out_a, out_b;
  logic        out_valid, ret_valid;
  logic [3:0]  out_tag, ret_tag;
  logic [2:0]  count;

  pipe_issue_queue #(
    .DEPTH(DEPTH), .CODE_W(16), .DATA_W(32), .PIPE_LAT(LAT), .TAG_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_a(in_a), .in_b(in_b),
    .hold(hold),
    .out_valid(out_valid), .out_code(out_code), .out_a(out_a), .out_b(out_b),
    .out_tag(out_tag),
    .ret_valid(ret_valid), .ret_tag(ret_tag),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] code;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
  } exp_t;

  typedef struct {
    logic [3:0] tag;
    int         due;
  } ret_t;

  exp_t exp_q[$];
  ret_t ret_q[$];

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         mcount  = 0;
  logic [3:0] push_seq = '0;
  logic       m_outv  = 1'b0;
  logic       m_acc, m_iss;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("[TB] ok   %s = %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_tests++;
    n_fail++;
    $display("[TB] FAIL %s: got event, expected none (cycle %0d)", name, cyc);
  endtask

  // Reference model: decides acceptance/issue from its own count.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcount   = 0;
      push_seq = '0;
      m_outv   = 1'b0;
      exp_q.delete();
      ret_q.delete();
    end else begin
      cyc++;
      m_acc = in_valid && (mcount < DEPTH);
      m_iss = (mcount > 0) && !hold;
      if (m_acc) begin
        exp_q.push_back(exp_t'{code: in_code, a: in_a, b: in_b, tag: push_seq});
        push_seq = push_seq + 4'd1;
      end
      mcount = mcount + int'(m_acc) - int'(m_iss);
      m_outv = m_iss;
    end
  end

  // Monitor: compares DUT outputs against the model once per cycle.
  always @(negedge clk) begin
    exp_t e;
    ret_t r;
    if (rst) begin
      check("out_valid", out_valid, m_outv);
      check("count", count, mcount);
      check("in_ready", in_ready, mcount < DEPTH);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          flag("issue_unexpected");
        end else begin
          e = exp_q.pop_front();
          check("out_code", out_code, e.code);
          check("out_a", out_a, e.a);
          check("out_b", out_b, e.b);
          check("out_tag", out_tag, e.tag);
          ret_q.push_back(ret_t'{tag: e.tag, due: cyc + LAT});
        end
      end else begin
        check("idle_code", out_code, OP_NOP);
        check("idle_ab", {out_a, out_b}, 64'd0);
      end
      if (ret_q.size() > 0 && ret_q[0].due < cyc) begin
        r = ret_q.pop_front();
        check("ret_missing_at", cyc, r.due);
      end
      if (ret_valid) begin
        if (ret_q.size() == 0) begin
          flag("ret_unexpected");
        end else begin
          r = ret_q.pop_front();
          check("ret_tag", ret_tag, r.tag);
          check("ret_cycle", cyc, r.due);
        end
      end
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [15:0] c, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    in_code  = c;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    bit seen;
    rst      = 1'b0;
    in_valid = 1'b1;
    hold     = 1'b0;
    in_code  = OP_ADD;
    in_a     = 32'd1;
    in_b     = 32'd2;
    repeat (2) @(posedge clk);
    #1;
    // 1: reset state while a producer is already offering data
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_code", out_code, 16'h0000);
    check("rst_count", count, 3'd0);
    check("rst_ret_valid", ret_valid, 1'b0);
    check("rst_out_tag", out_tag, 4'd0);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;

    // 2: single ADD, latency and retire timing come from the model
    drive(16'h0004, 32'h0000_0002, 32'h0000_0002);
    idle(8);

    // 3: fill under hold, fifth tuple refused, then drain in order
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(16'h0010 + 16'(i), 32'(i), ~32'(i));
    end
    in_valid = 1'b0;
    check("full_count", count, 3'd4);
    check("full_ready", in_ready, 1'b0);
    hold = 1'b0;
    idle(10);

    // 4: streaming with tag wrap from a fresh reset
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      drive(16'h0100 + 16'(i), 32'h1000 + 32'(i), 32'h2000 + 32'(i));
    end
    idle(10);

    // 5: reset with three queued and two in the retire pipe
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      hold = (i >= 3);
      drive(16'h0200 + 16'(i), 32'(i * 3), 32'(i * 5));
    end
    in_valid = 1'b0;
    check("mid_count_before", count, 3'd3);
    rst  = 1'b0;
    hold = 1'b0;
    #1;
    check("mid_count_rst", count, 3'd0);
    check("mid_ret_rst", ret_valid, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(6);
    drive(OP_ADD, 32'hDEAD_0001, 32'hBEEF_0002);
    in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        check("post_rst_tag", out_tag, 4'd0);
      end
    end
    if (!seen) flag("post_rst_issue_timeout");
    idle(8);

    check("exp_q_drained", exp_q.size(), 0);
    check("ret_q_drained", ret_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
